ifu_prefetch: RTL
=================

Name: ifu_prefetch

Overview:
- Parametrised instruction fetch unit: successor to the single-register PC-plus-one fetch path.
- Holds a fetch PC and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, each tagged with its PC, in a prefetch queue feeding decode over a valid/ready handshake.
- Accepts a redirect (branch/jump) that flushes all in-flight and queued work.

Parameters:
- XLEN, 32, instruction and PC width in bits.
- PC_STEP, 1, PC increment per fetch (1 = word addressing, 4 = byte addressing).
- DEPTH, 4, prefetch queue entries; power of two, ≥2.
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_o  out  1  fetch request this cycle.
- imem_addr_o  out  XLEN  fetch address; valid when imem_req_o=1.
- imem_rdata_i  in  XLEN  instruction; valid the cycle after the request.
- redirect_i  in  1  redirect strobe.
- redirect_pc_i  in  XLEN  new fetch PC.
- inst_valid_o  out  1  queue head valid.
- inst_ready_i  in  1  decode accepts head.
- inst_o  out  XLEN  head instruction.
- inst_pc_o  out  XLEN  head instruction's PC.

Behaviour:
- Reset (async, while rst=1):
  - fetch_pc=RESET_PC; queue empty; in-flight flag cleared.
  - imem_req_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
- pop = inst_valid_o & inst_ready_i.
- Issue condition: !redirect_i & (count + inflight − pop) < DEPTH, where count = queue occupancy and inflight = 1 if a response is due this cycle.
- When the issue condition holds:
  - imem_req_o=1, imem_addr_o=fetch_pc.
  - fetch_pc += PC_STEP, modulo 2^XLEN; wraps silently from all-ones to 0.
  - A pending entry {pc} is registered and marked in-flight.
- Response, cycle after the request: if in-flight and not squashed, push {imem_rdata_i, pending pc} at the queue tail.
- Overflow is impossible by the credit rule; the push-when-full case is an assertion target.
- Outputs:
  - inst_valid_o = (count≠0) & !redirect_i.
  - inst_o and inst_pc_o show the head combinationally and are 0 when empty.
- Simultaneous push and pop: both occur; count unchanged.
- Redirect cycle:
  - Queue cleared at clock edge and pop ignored.
  - Any response arriving next cycle is squashed.
  - fetch_pc <= redirect_pc_i.
  - No request issued this cycle; first request at redirect_pc_i is issued the next cycle.
- Back-to-back redirects: the last one wins; each squashes the response of the cycle before.
- Latency:
  - Request in cycle N gives inst_valid_o in cycle N+1 after the edge, i.e. the entry is visible from cycle N+2 onward.
  - First request after reset deassertion occurs in the first clock cycle.
- Throughput: one instruction per cycle sustained while inst_ready_i=1.
- Stall, inst_ready_i=0: queue fills to DEPTH, then imem_req_o=0 until a pop.
- Reset mid-operation: all state returns to reset values immediately; a response arriving after release is ignored.

Optional Feature:
- Macro IFU_PREFETCH_PERF_EN.
- When defined, adds 32-bit output ports, all reset to 0 and wrapping on overflow:
  - perf_fetch_o: count of pushes.
  - perf_stall_o: cycles where inst_valid_o=1 & inst_ready_i=0.
  - perf_flush_o: count of redirects.
- When undefined, these ports and their counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, PC_STEP=1, ready=1, memory returns data=addr+0x100 → requests at addresses 0,1,2,…; inst_valid_o from cycle 2 with (inst 0x100, pc 0), then (0x101, 1), … one per cycle, no gaps.
- inst_ready_i=0 from reset, DEPTH=4 → exactly 4 requests (addresses 0–3), imem_req_o=0 afterwards. Raise ready: drains pc 0,1,2,3 in order, then requests resume at address 4.
- Redirect to 0x40 while the queue holds 3 entries and a request is in flight → the next cycle has inst_valid_o=0 and the squashed response is not pushed. The request at 0x40 is issued the cycle after the redirect, and the first delivered pc is 0x40.
- Redirect in 2 consecutive cycles (0x40 then 0x80) → no 0x40 instruction is ever delivered; the first delivered pc is 0x80.
- RESET_PC=0xFFFFFFFE, PC_STEP=1 → delivered pcs are 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- rst asserted mid-stream with a full queue → outputs are 0 immediately without a clock edge; after release, fetch restarts at RESET_PC. With IFU_PREFETCH_PERF_EN defined, all three counters read 0.

Source files
------------

// File: rtl/ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ifu_prefetch
//
// This module is the instruction fetch unit with a prefetch queue. It holds a
// fetch PC and sends one request per cycle to a synchronous instruction memory
// that has a 1-cycle read latency. Each returned instruction is tagged with its
// PC and placed in a DEPTH-entry queue. Decode drains the queue over a
// valid/ready handshake. A redirect flushes all queued and in-flight work and
// restarts fetch at the new PC.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   imem_req_o     out  fetch request this cycle
//   imem_addr_o    out  fetch address (valid when imem_req_o=1)
//   imem_rdata_i   in   instruction, valid the cycle after the request
//   redirect_i     in   redirect strobe
//   redirect_pc_i  in   new fetch PC
//   inst_valid_o   out  queue head valid
//   inst_ready_i   in   decode accepts head
//   inst_o         out  head instruction (0 when empty)
//   inst_pc_o      out  head instruction's PC (0 when empty)
//
// Optional build macro IFU_PREFETCH_PERF_EN adds these 32-bit counters:
//   perf_fetch_o   pushes into the queue
//   perf_stall_o   cycles with inst_valid_o=1 and inst_ready_i=0
//   perf_flush_o   redirects
// ---------------------------------------------------------------------------
module ifu_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              PC_STEP  = 1,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
`ifdef IFU_PREFETCH_PERF_EN
  output logic [XLEN-1:0] inst_pc_o,
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_stall_o,
  output logic [31:0]     perf_flush_o
`else
  output logic [XLEN-1:0] inst_pc_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Fetch state
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_pend_pc;   // PC of the request whose data returns this cycle
  logic             r_inflight;  // a response is due this cycle

  // Queue state
  logic [XLEN-1:0]  r_q_inst [DEPTH];
  logic [XLEN-1:0]  r_q_pc   [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [CNT_W:0]   w_credit;

  // NOTE: every signal driven in always_comb gets a default first. That way
  // no path leaves a signal unassigned, and no latch is inferred.
  always_comb begin
    w_empty      = (r_count == '0);
    inst_valid_o = !w_empty && !redirect_i;
    w_pop        = inst_valid_o && inst_ready_i;
    // A redirect drops the response that arrives in the same cycle. Clearing
    // r_inflight on the redirect edge squashes anything after that.
    w_push       = r_inflight && !redirect_i;
    // Issue credit counts the queued entries plus the response on its way,
    // minus the entry leaving this cycle. If this is below DEPTH, the queue
    // always has room when the new request's data returns.
    w_credit     = {1'b0, r_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
    w_issue      = !rst && !redirect_i && (w_credit < (CNT_W+1)'(DEPTH));
    imem_req_o   = w_issue;
    imem_addr_o  = r_fetch_pc;
    inst_o       = '0;
    inst_pc_o    = '0;
    if (!w_empty) begin
      inst_o    = r_q_inst[r_rd_ptr];
      inst_pc_o = r_q_pc[r_rd_ptr];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Then every
  // register samples values from before the edge, whatever order the code
  // is written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_i) begin
      r_fetch_pc <= redirect_pc_i;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pend_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the queue storage has no reset. The entries are only seen through
  // r_count, which is reset, and the head outputs are forced to 0 when the
  // queue is empty. This keeps reset logic out of the RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= imem_rdata_i;
      r_q_pc[r_wr_ptr]   <= r_pend_pc;
    end
  end

  // The credit rule makes overflow unreachable. This assertion catches any
  // break in that reasoning.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == CNT_W'(DEPTH))));

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_push)                        r_perf_fetch <= r_perf_fetch + 32'd1;
      if (inst_valid_o && !inst_ready_i) r_perf_stall <= r_perf_stall + 32'd1;
      if (redirect_i)                    r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_fetch_o = r_perf_fetch;
  assign perf_stall_o = r_perf_stall;
  assign perf_flush_o = r_perf_flush;
`endif

endmodule
